mdu_unit: RTL and testbench

- Multiply/divide unit in the EXE stage.
- Consumes the decoder's MDU_Sel, Start and MDU_RD_Sel controls, plus forwarded rs/rt operands.
- Holds the architectural HI/LO registers, runs multi-cycle mult/multu/div/divu, and executes mthi/mtlo.
- Returns HI or LO for mfhi/mflo; the ALU/MDU output mux selects it via ALU_MDU_Sel.
- Busy goes to the hazard unit, which stalls IF/ID/EXE on any MDU instruction while the unit is occupied.

---
 rtl/mdu_unit.sv | 140 ++++++++++++++
 tb/tb_mdu_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EXE stage: owns HI/LO, runs multi-cycle
// mult/multu/div/divu from latched operands, and performs mthi/mtlo moves.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDU_Sel,
  input  logic        Start,
  input  logic        MDU_RD_Sel,
  output logic        Busy,
  output logic [31:0] MDU_Out,
  output logic [31:0] HI_q,
  output logic [31:0] LO_q
);

  // Start/Busy contract: Start is only honoured in IDLE with MDU_Sel 1..4;
  // Busy is high from the launching edge until the completion edge, and any
  // Start or move seen while Busy is high is dropped, never queued.

  localparam logic [2:0] SEL_MULT  = 3'd1;
  localparam logic [2:0] SEL_MULTU = 3'd2;
  localparam logic [2:0] SEL_DIV   = 3'd3;
  localparam logic [2:0] SEL_DIVU  = 3'd4;
  localparam logic [2:0] SEL_MTLO  = 3'd5;
  localparam logic [2:0] SEL_MTHI  = 3'd6;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  // state_q is the observable FSM state for checkers
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] res_hi, res_lo;
  logic [63:0] prod_s, prod_u;
  logic        signed_div;
  logic [31:0] div_n, div_d, div_d_safe, q_mag, r_mag;

  // Result datapath works only from latched operands.
  always_comb begin
    prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    signed_div = (op_q == SEL_DIV);
    div_n      = (signed_div && a_q[31]) ? -a_q : a_q;
    div_d      = (signed_div && b_q[31]) ? -b_q : b_q;
    div_d_safe = (div_d == 32'd0) ? 32'd1 : div_d;
    q_mag      = div_n / div_d_safe;
    r_mag      = div_n % div_d_safe;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (op_q)
      SEL_MULT:  {res_hi, res_lo} = prod_s;
      SEL_MULTU: {res_hi, res_lo} = prod_u;
      SEL_DIV, SEL_DIVU: begin
        if (b_q == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a_q;
        end else if (signed_div) begin
          // quotient truncates toward zero, remainder follows the dividend
          res_lo = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
          res_hi = a_q[31] ? -r_mag : r_mag;
        end else begin
          res_lo = q_mag;
          res_hi = r_mag;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start && (MDU_Sel inside {[SEL_MULT:SEL_DIVU]})) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          op_d    = MDU_Sel;
          cnt_d   = (MDU_Sel <= SEL_MULTU) ? MULT_N : DIV_N;
        end else if (MDU_Sel == SEL_MTLO) begin
          lo_d = A;
        end else if (MDU_Sel == SEL_MTHI) begin
          hi_d = A;
        end
      end
      RUN: begin
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign HI_q    = hi_q;
  assign LO_q    = lo_q;
  assign MDU_Out = MDU_RD_Sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed vectors, a cycle-level behavioural model of
// HI/LO/Busy checked every cycle, and literal expectations for each case.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [2:0]  MDU_Sel = 3'd0;
  logic        Start = 1'b0;
  logic        MDU_RD_Sel = 1'b0;
  logic        Busy;
  logic [31:0] MDU_Out, HI_q, LO_q;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDU_Sel(MDU_Sel), .Start(Start),
    .MDU_RD_Sel(MDU_RD_Sel), .Busy(Busy), .MDU_Out(MDU_Out), .HI_q(HI_q), .LO_q(LO_q)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: arithmetic from the instruction definitions
  function automatic logic [63:0] model_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (sel)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (Start && MDU_Sel >= 3'd1 && MDU_Sel <= 3'd4) begin
      {m_phi, m_plo} = model_op(MDU_Sel, A, B);
      m_rem = (MDU_Sel <= 3'd2) ? 5 : 10;
    end else if (MDU_Sel == 3'd5) begin
      m_lo = A;
    end else if (MDU_Sel == 3'd6) begin
      m_hi = A;
    end
  end

  // scoreboard: expected {Busy, HI, LO, MDU_Out} pushed by the model side
  logic [96:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      exp_q.push_back({(m_rem > 0), m_hi, m_lo, (MDU_RD_Sel ? m_hi : m_lo)});
    end
  end

  always @(negedge clk) begin
    logic [96:0] e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy", {31'd0, Busy}, {31'd0, e[96]});
      check("hi", HI_q, e[95:64]);
      check("lo", LO_q, e[63:32]);
      check("mdu_out", MDU_Out, e[31:0]);
    end
  end

  // driver tasks
  task automatic drive(input logic [2:0] sel, input logic st, input logic [31:0] a, input logic [31:0] b);
    MDU_Sel    = sel;
    Start      = st;
    A          = a;
    B          = b;
    MDU_RD_Sel = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'd0, 1'b0, $urandom, $urandom);
  endtask

  // after a launch edge: count busy cycles until idle, bounded
  task automatic busy_len(input string name, input int exp_n);
    int c;
    c = 0;
    while (Busy && c < 40) begin
      idle(1);
      c++;
    end
    check(name, c, exp_n);
  endtask

  task automatic check_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    check({name, "_hi"}, HI_q, hi);
    check({name, "_lo"}, LO_q, lo);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;
    MDU_RD_Sel = 1'b0;
    #1 check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_out_lo", MDU_Out, 32'd0);
    MDU_RD_Sel = 1'b1;
    #1 check("reset_out_hi", MDU_Out, 32'd0);
    idle(2);

    // mult -2 * 3, operands changed right after launch
    drive(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    busy_len("mult_busy", 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    idle(1);

    drive(3'd2, 1'b1, 32'hFFFF_FFFF, 32'd2);
    busy_len("multu_busy", 5);
    check_hilo("multu", 32'd1, 32'hFFFF_FFFE);

    drive(3'd3, 1'b1, -32'sd7, 32'd2);
    busy_len("div_busy", 10);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    drive(3'd4, 1'b1, 32'd100, 32'd0);
    busy_len("divu0_busy", 10);
    check_hilo("divu0", 32'd100, 32'hFFFF_FFFF);

    drive(3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("divovf_busy", 10);
    check_hilo("divovf", 32'd0, 32'h8000_0000);

    drive(3'd4, 1'b1, 32'd1000, 32'd7);
    busy_len("divu_busy", 10);
    check_hilo("divu", 32'd6, 32'd142);

    // moves at idle; mtlo carries a stray Start
    drive(3'd6, 1'b0, 32'h1234_5678, 32'd0);
    check("mthi", HI_q, 32'h1234_5678);
    drive(3'd5, 1'b1, 32'h0000_CAFE, 32'd9);
    check("mtlo", LO_q, 32'h0000_CAFE);
    check("mtlo_nobusy", {31'd0, Busy}, 32'd0);

    // mtlo and a second Start during Busy are both dropped
    drive(3'd1, 1'b1, 32'd7, 32'd6);
    drive(3'd5, 1'b0, 32'h0000_DEAD, 32'd0);
    drive(3'd3, 1'b1, 32'd50, 32'd5);
    busy_len("conflict_busy", 3);
    check_hilo("conflict", 32'd0, 32'd42);

    // Start coinciding with the completion edge is ignored
    drive(3'd2, 1'b1, 32'd3, 32'd3);
    idle(4);
    drive(3'd2, 1'b1, 32'd5, 32'd5);
    check("complete_start_busy", {31'd0, Busy}, 32'd0);
    check_hilo("complete_start", 32'd0, 32'd9);
    idle(1);

    // reset aborts a running div
    drive(3'd6, 1'b0, 32'hAAAA_5555, 32'd0);
    drive(3'd3, 1'b1, 32'd100, 32'd7);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check_hilo("abort", 32'd0, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(12);
    check_hilo("after_abort", 32'd0, 32'd0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
